// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions used by the pipeline control blocks.
package cpu_types_pkg;

  // Architectural register index.
  typedef logic [4:0] regbits_t;

endpackage : cpu_types_pkg

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the five-stage pipeline. It decides each cycle
// whether the PC and each pipeline latch advance, hold or take a bubble. It
// covers load-use, taken redirects, fetch misses, data-memory waits and halt.
// It also keeps saturating stall counters for performance debug.
// state_dbg exposes the FSM state: 0=RUN, 1=DWAIT, 2=HALT.
module pipeline_ctrl
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        exm_dREN,
  input  logic        exm_dWEN,
  input  logic        exm_halt,
  input  logic        ex_redirect,
  input  logic        idex_dREN,
  input  regbits_t    idex_rt_out,
  input  regbits_t    ifid_rs,
  input  regbits_t    ifid_rt,
  input  logic        ifid_uses_rt,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        mwb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        halt,
  output logic [15:0] stall_cnt,
  output logic [15:0] dwait_cnt,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DWAIT = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  state_e      state_q, state_d;
  logic        halt_q, halt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] dwait_cnt_q, dwait_cnt_d;

  logic mem_busy;
  logic load_use;
  logic mem_freeze;

  // Hazard detection shared by RUN and DWAIT. Register 0 never causes a load-use.
  always_comb begin
    mem_busy = (exm_dREN | exm_dWEN) & ~dhit;
    load_use = idex_dREN & (idex_rt_out != 5'd0) &
               ((idex_rt_out == ifid_rs) | (ifid_uses_rt & (idex_rt_out == ifid_rt)));
  end

  // State, halt flag and counters; reset returns to RUN with everything cleared.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= S_RUN;
      halt_q      <= 1'b0;
      stall_cnt_q <= 16'd0;
      dwait_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      halt_q      <= halt_d;
      stall_cnt_q <= stall_cnt_d;
      dwait_cnt_q <= dwait_cnt_d;
    end
  end

  // Next state: halt beats a memory wait; every other rule returns to RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HALT: state_d = S_HALT;
      default: begin
        if (exm_halt)      state_d = S_HALT;
        else if (mem_busy) state_d = S_DWAIT;
        else               state_d = S_RUN;
      end
    endcase
  end

  // Enables and flushes: the first matching rule wins. A flushed latch loads
  // zeros whatever its enable says.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    mwb_en      = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    mem_freeze  = 1'b0;
    case (state_q)
      S_HALT: begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        mwb_en   = 1'b0;
      end
      default: begin
        if (exm_halt) begin
          // The halt instruction retires into MEM/WB; nothing behind it moves.
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_en     = 1'b0;
          exmem_en    = 1'b0;
          exmem_flush = 1'b1;
        end else if (mem_busy) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_en    = 1'b0;
          exmem_en   = 1'b0;
          mwb_en     = 1'b0;
          mem_freeze = 1'b1;
        end else if (ex_redirect) begin
          // The redirect target is fetched regardless of the current ihit.
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (load_use) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end else if (!ihit) begin
          pc_en      = 1'b0;
          ifid_flush = 1'b1;
        end
      end
    endcase
  end

  // Sticky halt and saturating performance counters.
  always_comb begin
    halt_d      = halt_q | (state_d == S_HALT);
    stall_cnt_d = stall_cnt_q;
    dwait_cnt_d = dwait_cnt_q;
    if (!pc_en && (state_q != S_HALT) && (stall_cnt_q != CNT_MAX))
      stall_cnt_d = stall_cnt_q + 16'd1;
    if (mem_freeze && (dwait_cnt_q != CNT_MAX))
      dwait_cnt_d = dwait_cnt_q + 16'd1;
  end

  assign halt      = halt_q;
  assign stall_cnt = stall_cnt_q;
  assign dwait_cnt = dwait_cnt_q;
  assign state_dbg = state_q;

endmodule : pipeline_ctrl

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with hand-computed expected values.
module tb_pipeline_ctrl;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit, dhit, exm_dREN, exm_dWEN, exm_halt, ex_redirect;
  logic        idex_dREN, ifid_uses_rt;
  logic [4:0]  idex_rt_out, ifid_rs, ifid_rt;
  logic        pc_en, ifid_en, idex_en, exmem_en, mwb_en;
  logic        ifid_flush, idex_flush, exmem_flush, halt;
  logic [15:0] stall_cnt, dwait_cnt;
  logic [1:0]  state_dbg;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [1:0] RUN = 2'd0, DWAIT = 2'd1, HALTED = 2'd2;

  // Clock and DUT
  always #5 CLK = ~CLK;

  pipeline_ctrl dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .exm_dREN(exm_dREN), .exm_dWEN(exm_dWEN), .exm_halt(exm_halt),
    .ex_redirect(ex_redirect), .idex_dREN(idex_dREN), .idex_rt_out(idex_rt_out),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .mwb_en(mwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .halt(halt), .stall_cnt(stall_cnt),
    .dwait_cnt(dwait_cnt), .state_dbg(state_dbg)
  );

  // Driver tasks
  task automatic idle();
    ihit = 1'b1; dhit = 1'b0; exm_dREN = 1'b0; exm_dWEN = 1'b0; exm_halt = 1'b0;
    ex_redirect = 1'b0; idex_dREN = 1'b0; ifid_uses_rt = 1'b0;
    idex_rt_out = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
  endtask

  // Advance one edge, leave time 1 after it so inputs change away from the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Immediate-assertion comparison point.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Combinational outputs checked 2 time units after inputs settle.
  // en = {pc,ifid,idex,exmem,mwb}, fl = {ifid,idex,exmem}.
  task automatic chk_out(input string tag, input logic [4:0] en, input logic [2:0] fl);
    #2;
    chk({tag, "_en"}, {27'd0, pc_en, ifid_en, idex_en, exmem_en, mwb_en}, {27'd0, en});
    chk({tag, "_fl"}, {29'd0, ifid_flush, idex_flush, exmem_flush}, {29'd0, fl});
  endtask

  task automatic chk_regs(input string tag, input logic [1:0] st, input logic h,
                          input logic [15:0] sc, input logic [15:0] dc);
    chk({tag, "_state"}, {30'd0, state_dbg}, {30'd0, st});
    chk({tag, "_halt"}, {31'd0, halt}, {31'd0, h});
    chk({tag, "_stall"}, {16'd0, stall_cnt}, {16'd0, sc});
    chk({tag, "_dwait"}, {16'd0, dwait_cnt}, {16'd0, dc});
  endtask

  initial begin
    // Reset: outputs follow RUN rules from the inputs while held.
    idle();
    nRST = 1'b0;
    #3;
    chk_regs("reset", RUN, 1'b0, 16'd0, 16'd0);
    chk_out("reset", 5'b11111, 3'b000);
    tick();
    nRST = 1'b1;

    // No hazards for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      chk_out("idle", 5'b11111, 3'b000);
      tick();
    end
    chk_regs("idle", RUN, 1'b0, 16'd0, 16'd0);

    // Load-use on rs: exactly one bubble.
    idex_dREN = 1'b1; idex_rt_out = 5'd8; ifid_rs = 5'd8;
    chk_out("lu_rs", 5'b00111, 3'b010);
    tick();
    idle();
    chk_out("lu_after", 5'b11111, 3'b000);
    chk_regs("lu_rs", RUN, 1'b0, 16'd1, 16'd0);

    // Destination r0 never stalls.
    idex_dREN = 1'b1; idex_rt_out = 5'd0; ifid_rs = 5'd0;
    chk_out("lu_r0", 5'b11111, 3'b000);
    tick();
    chk_regs("lu_r0", RUN, 1'b0, 16'd1, 16'd0);

    // rt match only counts when the ID instruction reads rt.
    idle();
    idex_dREN = 1'b1; idex_rt_out = 5'd9; ifid_rs = 5'd3; ifid_rt = 5'd9; ifid_uses_rt = 1'b0;
    chk_out("lu_rt_unused", 5'b11111, 3'b000);
    ifid_uses_rt = 1'b1;
    chk_out("lu_rt_used", 5'b00111, 3'b010);
    tick();
    idle();
    chk_regs("lu_rt", RUN, 1'b0, 16'd2, 16'd0);

    // Zero-wait data hit stays in RUN.
    exm_dREN = 1'b1; dhit = 1'b1;
    chk_out("dhit0", 5'b11111, 3'b000);
    tick();
    chk_regs("dhit0", RUN, 1'b0, 16'd2, 16'd0);

    // Three-cycle data miss, then the hit cycle advances with no extra bubble.
    dhit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_out("dmiss", 5'b00000, 3'b000);
      tick();
      chk({"dmiss_state"}, {30'd0, state_dbg}, {30'd0, DWAIT});
    end
    dhit = 1'b1;
    chk_out("dmiss_hit", 5'b11111, 3'b000);
    tick();
    idle();
    chk_regs("dmiss", RUN, 1'b0, 16'd5, 16'd3);

    // Redirect while the fetch misses: PC still advances, two bubbles.
    ex_redirect = 1'b1; ihit = 1'b0;
    chk_out("redir", 5'b11111, 3'b110);
    tick();
    chk_regs("redir", RUN, 1'b0, 16'd5, 16'd3);

    // Redirect beats load-use: no stall counted.
    ihit = 1'b1; idex_dREN = 1'b1; idex_rt_out = 5'd4; ifid_rs = 5'd4;
    chk_out("redir_lu", 5'b11111, 3'b110);
    tick();
    idle();
    chk_regs("redir_lu", RUN, 1'b0, 16'd5, 16'd3);

    // Plain fetch miss: PC holds, IF/ID takes a bubble, downstream advances.
    ihit = 1'b0;
    chk_out("imiss", 5'b01111, 3'b100);
    tick();
    idle();
    chk_regs("imiss", RUN, 1'b0, 16'd6, 16'd3);

    // Memory wait beats redirect; the redirect resolves once the hit arrives.
    ex_redirect = 1'b1; exm_dWEN = 1'b1; dhit = 1'b0;
    chk_out("redir_busy", 5'b00000, 3'b000);
    tick();
    chk_regs("redir_busy", DWAIT, 1'b0, 16'd7, 16'd4);
    dhit = 1'b1;
    chk_out("redir_busy_hit", 5'b11111, 3'b110);
    tick();
    idle();
    chk_regs("redir_busy_hit", RUN, 1'b0, 16'd7, 16'd4);

    // Reset in the middle of DWAIT clears everything at once.
    exm_dREN = 1'b1; dhit = 1'b0;
    tick();
    chk_regs("dwait_pre_rst", DWAIT, 1'b0, 16'd8, 16'd5);
    #2;
    nRST = 1'b0;
    #1;
    chk_regs("dwait_rst", RUN, 1'b0, 16'd0, 16'd0);
    idle();
    tick();
    nRST = 1'b1;

    // Halt: one retire cycle, then frozen for good.
    exm_halt = 1'b1;
    chk_out("halt_retire", 5'b00001, 3'b001);
    tick();
    idle();
    chk_regs("halt", HALTED, 1'b1, 16'd1, 16'd0);
    ex_redirect = 1'b1; ihit = 1'b0; exm_dREN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_out("halted", 5'b00000, 3'b000);
      tick();
    end
    chk_regs("halted", HALTED, 1'b1, 16'd1, 16'd0);
    idle();
    #2;
    nRST = 1'b0;
    #1;
    chk_regs("halt_rst", RUN, 1'b0, 16'd0, 16'd0);
    tick();
    nRST = 1'b1;

    // Long fetch miss saturates the stall counter.
    ihit = 1'b0;
    repeat (65534) tick();
    chk({"sat_fffe"}, {16'd0, stall_cnt}, 32'h0000_FFFE);
    tick();
    chk({"sat_ffff"}, {16'd0, stall_cnt}, 32'h0000_FFFF);
    repeat (70000 - 65535) tick();
    chk_regs("sat_hold", RUN, 1'b0, 16'hFFFF, 16'd0);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_pipeline_ctrl
